// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: shares one serial transmit engine between two character
// sources. Round-robin per character, a source keeps the grant until its
// end-of-message character, and the block tracks the output column.
// Optional feature macro: AUTO_CRLF_EN inserts CR/LF when a printable
// character would be sent at column COLS.
module serial_tx_arbiter #(
    parameter int COLS         = 80,
    parameter int BUSY_TIMEOUT = 16,
    parameter bit MARK_BIT7    = 1'b1
) (
    input  logic       clk100,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_eom,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_eom,
    output logic       req1_ready,
    output logic [7:0] txe_data,
    output logic       txe_start,
    input  logic       txe_busy,
    output logic [1:0] grant,
    output logic [6:0] column,
    output logic       timeout_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
`ifdef AUTO_CRLF_EN
    localparam logic [2:0] S_INS_CR  = 3'd2;
    localparam logic [2:0] S_INS_LF  = 3'd3;
    // Which character is currently in flight through START..WAIT_DN.
    localparam logic [1:0] PH_CHAR   = 2'd0;
    localparam logic [1:0] PH_CR     = 2'd1;
    localparam logic [1:0] PH_LF     = 2'd2;
`endif
    localparam logic [2:0] S_START   = 3'd4;
    localparam logic [2:0] S_WAIT_UP = 3'd5;
    localparam logic [2:0] S_WAIT_DN = 3'd6;

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    logic [2:0]    state;
    logic [7:0]    hold;
    logic          hold_eom;
    logic          last_srv;
    logic [TW-1:0] to_cnt;
    logic          win_vld;
    logic          win_idx;
    logic          accept;
`ifdef AUTO_CRLF_EN
    logic [1:0]    phase;
`endif

    function automatic logic [7:0] mark(input logic [7:0] d);
        return MARK_BIT7 ? {1'b1, d[6:0]} : d;
    endfunction

    function automatic logic printable(input logic [7:0] ch);
        return (ch[6:0] >= 7'h20) && (ch[6:0] <= 7'h7E);
    endfunction

    function automatic logic [6:0] col_next(input logic [6:0] col, input logic [7:0] ch);
        logic [6:0] r;
        r = col;
        if (printable(ch)) begin
            if (col != 7'd127) r = col + 7'd1;
        end else if (ch[6:0] == 7'h0D) begin
            r = 7'd0;
        end else if (ch[6:0] == 7'h08) begin
            if (col != 7'd0) r = col - 7'd1;
        end
        return r;
    endfunction

    // Winner selection: the current owner is the only candidate; otherwise
    // round-robin against the last served source.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 1'b0;
        if (grant != 2'b00) begin
            win_idx = grant[1];
            win_vld = grant[1] ? req1_valid : req0_valid;
        end else if (req0_valid && req1_valid) begin
            win_idx = ~last_srv;
            win_vld = 1'b1;
        end else if (req0_valid) begin
            win_idx = 1'b0;
            win_vld = 1'b1;
        end else if (req1_valid) begin
            win_idx = 1'b1;
            win_vld = 1'b1;
        end
    end

    // An engine that is already busy (owned elsewhere) blocks acceptance.
    assign accept     = (state == S_IDLE) && !txe_busy && win_vld;
    assign req0_ready = accept && !win_idx;
    assign req1_ready = accept && win_idx;
    assign txe_start  = (state == S_START);

    // Control FSM, hold register, column tracking and timeout detection.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            hold        <= 8'h00;
            hold_eom    <= 1'b0;
            last_srv    <= 1'b1;
            to_cnt      <= '0;
            txe_data    <= 8'h00;
            grant       <= 2'b00;
            column      <= 7'd0;
            timeout_err <= 1'b0;
`ifdef AUTO_CRLF_EN
            phase       <= PH_CHAR;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        hold     <= win_idx ? req1_data : req0_data;
                        hold_eom <= win_idx ? req1_eom : req0_eom;
                        grant    <= win_idx ? 2'b10 : 2'b01;
                        last_srv <= win_idx;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
`ifdef AUTO_CRLF_EN
                    if (printable(hold) && (column == 7'(COLS))) begin
                        state <= S_INS_CR;
                    end else begin
                        txe_data <= mark(hold);
                        phase    <= PH_CHAR;
                        state    <= S_START;
                    end
`else
                    txe_data <= mark(hold);
                    state    <= S_START;
`endif
                end
`ifdef AUTO_CRLF_EN
                S_INS_CR: begin
                    txe_data <= mark(8'h0D);
                    phase    <= PH_CR;
                    state    <= S_START;
                end
                S_INS_LF: begin
                    txe_data <= mark(8'h0A);
                    phase    <= PH_LF;
                    state    <= S_START;
                end
`endif
                S_START: begin
                    to_cnt <= '0;
                    state  <= S_WAIT_UP;
                end
                S_WAIT_UP: begin
                    if (txe_busy) begin
                        state <= S_WAIT_DN;
                    end else if (to_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                        // Engine never answered: drop the character, keep eom release.
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                        if (hold_eom) grant <= 2'b00;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                S_WAIT_DN: begin
                    if (!txe_busy) begin
                        column <= col_next(column, txe_data);
`ifdef AUTO_CRLF_EN
                        if (phase == PH_CR) begin
                            state <= S_INS_LF;
                        end else if (phase == PH_LF) begin
                            // Column is now 0, so LOAD sends the held character.
                            state <= S_LOAD;
                        end else begin
                            state <= S_IDLE;
                            if (hold_eom) grant <= 2'b00;
                        end
`else
                        state <= S_IDLE;
                        if (hold_eom) grant <= 2'b00;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
